// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for the processor data port. Decodes
//                each word access into a word RAM, a console TX FIFO that
//                drives a valid/ready byte stream, and a free-running 32-bit
//                cycle counter. Loads are combinational; stores commit on
//                the rising clock edge.
//
//  Ports
//    clk             in   1   single clock, all state updates on posedge
//    reset_n         in   1   asynchronous active-low reset
//    WE              in   1   store enable from the processor
//    address_to_mem  in  32   byte address, bits [1:0] ignored
//    data_to_mem     in  32   store data
//    data_from_mem   out 32   load data, combinational
//    tx_data         out  8   console byte at FIFO head (0 while empty)
//    tx_valid        out  1   FIFO non-empty
//    tx_ready        in   1   sink accepts tx_data this cycle
//
//  Address map
//    0 .. RAM_WORDS*4-1   RAM
//    0xFFFF_FFF0          CON_DATA  (W: push byte, R: 0)
//    0xFFFF_FFF4          CON_STAT  (R: {overflow, full, empty}, W: bit2 clears overflow)
//    0xFFFF_FFF8          CYCLES    (R: counter, W: load counter)
//
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4     // power of two, >= 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] c_RAM_BYTES = RAM_WORDS * 4;
    localparam int          c_IW        = $clog2(FIFO_DEPTH);
    localparam int          c_PW        = c_IW + 1;

    localparam logic [31:0] c_ADDR_CON_DATA = 32'hFFFF_FFF0;
    localparam logic [31:0] c_ADDR_CON_STAT = 32'hFFFF_FFF4;
    localparam logic [31:0] c_ADDR_CYCLES   = 32'hFFFF_FFF8;

    localparam logic [c_PW-1:0] c_PTR_ONE    = 1;
    localparam logic [31:0]     c_CYCLES_ONE = 32'd1;

    // ------------------------------------------------------------------------
    // Address decode (word access only: the two byte-lane bits are dropped)
    // ------------------------------------------------------------------------
    logic [31:0]         w_word_addr;
    logic                w_sel_ram;
    logic                w_sel_con_data;
    logic                w_sel_con_stat;
    logic                w_sel_cycles;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_unused_addr_lsb;

    assign w_word_addr       = {address_to_mem[31:2], 2'b00};
    assign w_sel_ram         = (w_word_addr < c_RAM_BYTES);
    assign w_sel_con_data    = (w_word_addr == c_ADDR_CON_DATA);
    assign w_sel_con_stat    = (w_word_addr == c_ADDR_CON_STAT);
    assign w_sel_cycles      = (w_word_addr == c_ADDR_CYCLES);
    assign w_ram_idx         = address_to_mem[c_RAM_AW+1:2];
    assign w_unused_addr_lsb = ^address_to_mem[1:0];

    // ------------------------------------------------------------------------
    // Word RAM: no reset, contents survive reset pulses
    // ------------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (WE && w_sel_ram) begin
            r_ram[w_ram_idx] <= data_to_mem;
        end
    end

    // ------------------------------------------------------------------------
    // Console TX FIFO
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate count register.
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [7:0]      r_fifo_mem [FIFO_DEPTH];
    logic            r_overflow;

    logic [c_IW-1:0] w_wr_idx;
    logic [c_IW-1:0] w_rd_idx;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_overflow_set;
    logic            w_overflow_clr;

    assign w_wr_idx = r_wr_ptr[c_IW-1:0];
    assign w_rd_idx = r_rd_ptr[c_IW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]);

    assign w_push_req = WE && w_sel_con_data;
    assign w_pop      = !w_empty && tx_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot the write index points at, so the push can land there this edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign w_overflow_set = w_push_req && w_full && !w_pop;
    assign w_overflow_clr = WE && w_sel_con_stat && data_to_mem[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // Set takes precedence over clear
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (w_overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_mem[w_wr_idx] <= data_to_mem[7:0];
        end
    end

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo_mem[w_rd_idx];

    // ------------------------------------------------------------------------
    // Free-running cycle counter; a CYCLES store overrides the increment
    // ------------------------------------------------------------------------
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (WE && w_sel_cycles) begin
            r_cycles <= data_to_mem;
        end else begin
            r_cycles <= r_cycles + c_CYCLES_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Load data mux: reflects pre-edge state
    // ------------------------------------------------------------------------
    always_comb begin
        data_from_mem = 32'h0000_0000;
        if (w_sel_ram) begin
            data_from_mem = r_ram[w_ram_idx];
        end else if (w_sel_con_stat) begin
            data_from_mem = {29'b0, r_overflow, w_full, w_empty};
        end else if (w_sel_cycles) begin
            data_from_mem = r_cycles;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam logic [31:0] c_CON_DATA = 32'hFFFF_FFF0;
    localparam logic [31:0] c_CON_STAT = 32'hFFFF_FFF4;
    localparam logic [31:0] c_CYCLES   = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset_n;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int tests;
    int fails;

    data_mem_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .WE             (WE),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle store: driven after a negedge, committed on the next
    // posedge, returns 1 time unit after that edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        WE             = 1'b1;
        address_to_mem = a;
        data_to_mem    = d;
        @(posedge clk);
        #1;
        WE             = 1'b0;
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        WE             = 1'b0;
        tx_ready       = 1'b0;
        address_to_mem = '0;
        data_to_mem    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
        end
        tests++;
        if (tx_data !== 8'h00) begin
            fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data);
        end
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h1) begin
            fails++; $display("FAIL reset_stat: got %h want 00000001", data_from_mem);
        end
        address_to_mem = c_CYCLES; #1;
        tests++;
        if (data_from_mem !== 32'h0) begin
            fails++; $display("FAIL reset_cycles: got %h want 00000000", data_from_mem);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (data_from_mem !== 32'd5) begin
            fails++; $display("FAIL cycles_after_5: got %0d want 5", data_from_mem);
        end
    endtask

    task automatic test_ram;
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        address_to_mem = 32'h0000_0010; #1;
        tests++;
        if (data_from_mem !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL ram_rd_10: got %h want deadbeef", data_from_mem);
        end
        // Byte-lane bits are ignored on both store and load
        bus_write(32'h0000_0017, 32'h1234_5678);
        address_to_mem = 32'h0000_0015; #1;
        tests++;
        if (data_from_mem !== 32'h1234_5678) begin
            fails++; $display("FAIL ram_lsb_ignored: got %h want 12345678", data_from_mem);
        end
        // Last RAM word and the first address past it
        bus_write(32'h0000_00FC, 32'hA5A5_0001);
        bus_write(32'h0000_0000, 32'h1111_1111);
        bus_write(32'h0000_0100, 32'h0000_0BAD);
        address_to_mem = 32'h0000_00FC; #1;
        tests++;
        if (data_from_mem !== 32'hA5A5_0001) begin
            fails++; $display("FAIL ram_last_word: got %h want a5a50001", data_from_mem);
        end
        address_to_mem = 32'h0000_0100; #1;
        tests++;
        if (data_from_mem !== 32'h0) begin
            fails++; $display("FAIL ram_past_end: got %h want 00000000", data_from_mem);
        end
        address_to_mem = 32'h0000_0000; #1;
        tests++;
        if (data_from_mem !== 32'h1111_1111) begin
            fails++; $display("FAIL ram_no_alias: got %h want 11111111", data_from_mem);
        end
        address_to_mem = 32'h0000_1000; #1;
        tests++;
        if (data_from_mem !== 32'h0) begin
            fails++; $display("FAIL unmapped_rd: got %h want 00000000", data_from_mem);
        end
        // RAM survives a reset pulse
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        address_to_mem = 32'h0000_0010; #1;
        tests++;
        if (data_from_mem !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL ram_after_reset: got %h want deadbeef", data_from_mem);
        end
    endtask

    task automatic test_fifo_overflow;
        logic [7:0] exp_b [4];
        exp_b = '{8'h41, 8'h42, 8'h43, 8'h44};
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(c_CON_DATA, {24'h0, exp_b[i]});
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h2) begin
            fails++; $display("FAIL stat_full: got %h want 00000002", data_from_mem);
        end
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            fails++; $display("FAIL head_A: got v=%b d=%h want v=1 d=41", tx_valid, tx_data);
        end
        bus_write(c_CON_DATA, 32'h45);
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h6) begin
            fails++; $display("FAIL stat_overflow: got %h want 00000006", data_from_mem);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                fails++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL drain_empty: got v=%b want 0", tx_valid);
        end
        tx_ready = 1'b0;
        tests++;
        if (data_from_mem !== 32'h5) begin
            fails++; $display("FAIL stat_after_drain: got %h want 00000005", data_from_mem);
        end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp_b [4];
        exp_b = '{8'h42, 8'h43, 8'h44, 8'h58};
        bus_write(c_CON_STAT, 32'h4);
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h1) begin
            fails++; $display("FAIL stat_cleared: got %h want 00000001", data_from_mem);
        end
        tx_ready = 1'b0;
        bus_write(c_CON_DATA, 32'h41);
        bus_write(c_CON_DATA, 32'h42);
        bus_write(c_CON_DATA, 32'h43);
        bus_write(c_CON_DATA, 32'h44);
        // Push 'X' in the same cycle that 'A' is popped from a full FIFO
        @(negedge clk);
        tx_ready       = 1'b1;
        WE             = 1'b1;
        address_to_mem = c_CON_DATA;
        data_to_mem    = 32'h58;
        #1;
        tests++;
        if (tx_data !== 8'h41) begin
            fails++; $display("FAIL full_pop_head: got %h want 41", tx_data);
        end
        @(posedge clk);
        #1;
        WE             = 1'b0;
        tx_ready       = 1'b0;
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h2) begin
            fails++; $display("FAIL full_push_pop_stat: got %h want 00000002", data_from_mem);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                fails++; $display("FAIL pp_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL pp_drain_empty: got v=%b want 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        // Push and pop request on an empty FIFO: byte accepted, shown next cycle
        @(negedge clk);
        tx_ready       = 1'b1;
        WE             = 1'b1;
        address_to_mem = c_CON_DATA;
        data_to_mem    = 32'h51;
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL empty_pushpop_pre: got v=%b want 0", tx_valid);
        end
        @(posedge clk);
        #1;
        data_to_mem = 32'h52;
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h51) begin
            fails++; $display("FAIL empty_pushpop_post: got v=%b d=%h want v=1 d=51", tx_valid, tx_data);
        end
        @(posedge clk);
        #1;
        WE = 1'b0;
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h52) begin
            fails++; $display("FAIL b2b_second: got v=%b d=%h want v=1 d=52", tx_valid, tx_data);
        end
        @(posedge clk);
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_empty: got v=%b want 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_cycles;
        bus_write(c_CYCLES, 32'hFFFF_FFFE);
        address_to_mem = c_CYCLES; #1;
        tests++;
        if (data_from_mem !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL cyc_load: got %h want fffffffe", data_from_mem);
        end
        @(posedge clk); #1;
        tests++;
        if (data_from_mem !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL cyc_inc: got %h want ffffffff", data_from_mem);
        end
        @(posedge clk); #1;
        tests++;
        if (data_from_mem !== 32'h0) begin
            fails++; $display("FAIL cyc_wrap: got %h want 00000000", data_from_mem);
        end
        // Build an overflow, check only bit 2 clears it
        for (int i = 0; i < 5; i++) bus_write(c_CON_DATA, 32'h61 + i);
        bus_write(c_CON_STAT, 32'hFFFF_FFFB);
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h6) begin
            fails++; $display("FAIL stat_no_clear: got %h want 00000006", data_from_mem);
        end
        bus_write(c_CON_STAT, 32'h4);
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h2) begin
            fails++; $display("FAIL stat_clear_bit2: got %h want 00000002", data_from_mem);
        end
    endtask

    task automatic test_reset_midop;
        // FIFO holds 4 bytes from the previous test; reset must drop them all
        bus_write(c_CON_STAT, 32'h4);
        tests++;
        if (tx_valid !== 1'b1) begin
            fails++; $display("FAIL midop_pre_valid: got v=%b want 1", tx_valid);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            fails++; $display("FAIL midop_async_drop: got v=%b d=%h want v=0 d=00", tx_valid, tx_data);
        end
        address_to_mem = c_CYCLES; #1;
        tests++;
        if (data_from_mem !== 32'h0) begin
            fails++; $display("FAIL midop_cycles: got %h want 00000000", data_from_mem);
        end
        @(negedge clk);
        reset_n = 1'b1;
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h1) begin
            fails++; $display("FAIL midop_stat: got %h want 00000001", data_from_mem);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (tx_valid !== 1'b0) begin
                fails++; $display("FAIL midop_stale_%0d: got v=%b d=%h want v=0", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b0;
        // Three fresh pushes after reset land in order from an empty FIFO
        bus_write(c_CON_DATA, 32'h71);
        bus_write(c_CON_DATA, 32'h72);
        bus_write(c_CON_DATA, 32'h73);
        address_to_mem = c_CON_STAT; #1;
        tests++;
        if (data_from_mem !== 32'h0 || tx_data !== 8'h71) begin
            fails++; $display("FAIL post_reset_push: got stat=%h d=%h want stat=0 d=71", data_from_mem, tx_data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_cycles();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
